console_writer: RTL

// Write-side counterpart of the VGA text display: accepts a byte stream of character

---
 rtl/console_writer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/console_writer.sv
// Console writer: turns a character byte stream into screen-RAM writes with cursor, CR/LF/BS and clears.
// Latency: printable char written the cycle after accept, 1 char / 2 cycles; CLRLINE COLS cycles, CLEAR ROWS*COLS cycles.
// Backpressure: char_ready high only in IDLE; optional `CONSOLE_TAB_EN enables TAB to next 8-column stop.
module console_writer #(
    parameter int COLS = 40,
    parameter int ROWS = 30,
    parameter int AW   = 11,
    parameter int CW   = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          char_valid,
    input  logic [CW-1:0] char_data,
    output logic          char_ready,
    input  logic          clear_req,
    output logic          scr_we,
    output logic [AW-1:0] scr_addr,
    output logic [CW-1:0] scr_wdata,
    output logic [AW-1:0] cursor_addr,
    output logic          busy
);
    localparam int CBW = $clog2(COLS);
    localparam int RBW = $clog2(ROWS);
    localparam logic [CBW-1:0] COL_LAST = CBW'(COLS - 1);
    localparam logic [RBW-1:0] ROW_LAST = RBW'(ROWS - 1);
    localparam logic [AW-1:0]  COLS_A   = AW'(COLS);
    localparam logic [AW-1:0]  COLS_M1  = AW'(COLS - 1);
    localparam logic [AW-1:0]  SCR_LAST = AW'(ROWS * COLS - 1);
    localparam logic [CW-1:0]  SPACE    = CW'(32);
    localparam logic [CW-1:0]  CODE_BS  = CW'(8);
    localparam logic [CW-1:0]  CODE_LF  = CW'(10);
    localparam logic [CW-1:0]  CODE_CR  = CW'(13);

    typedef enum logic [1:0] {IDLE, WRITE, CLRLINE, CLEAR} state_t;

    state_t         state, state_n;
    logic [CBW-1:0] col, col_n;
    logic [RBW-1:0] row, row_n;
    logic [AW-1:0]  cur_n, addr_n;
    logic [CW-1:0]  wdata_n;
    logic           we_n, wrap_pend, wrap_n, do_nl;

    logic [AW-1:0]  line_start, nl_cur;
    logic [RBW-1:0] nl_row;
    logic           row_wrap;

    assign line_start = cursor_addr - AW'(col);
    assign row_wrap   = (row == ROW_LAST);
    assign nl_row     = row_wrap ? '0 : row + 1'b1;
    assign nl_cur     = row_wrap ? '0 : line_start + COLS_A;

`ifdef CONSOLE_TAB_EN
    logic [CBW:0] tab_next;
    assign tab_next = ({1'b0, col} | (CBW+1)'(7)) + 1'b1;
`endif

    always_comb begin
        state_n = state;
        col_n   = col;
        row_n   = row;
        cur_n   = cursor_addr;
        we_n    = 1'b0;
        addr_n  = scr_addr;
        wdata_n = scr_wdata;
        wrap_n  = wrap_pend;
        do_nl   = 1'b0;
        case (state)
            IDLE: begin
                if (clear_req) begin
                    state_n = CLEAR;
                    we_n    = 1'b1;
                    addr_n  = '0;
                    wdata_n = SPACE;
                end else if (char_valid && char_ready) begin
                    if (char_data >= SPACE) begin
                        state_n = WRITE;
                        we_n    = 1'b1;
                        addr_n  = cursor_addr;
                        wdata_n = char_data;
                        if (col == COL_LAST) begin
                            col_n  = '0;
                            row_n  = nl_row;
                            cur_n  = nl_cur;
                            wrap_n = row_wrap;
                        end else begin
                            col_n  = col + 1'b1;
                            cur_n  = cursor_addr + 1'b1;
                            wrap_n = 1'b0;
                        end
                    end else begin
                        case (char_data)
                            CODE_CR: begin
                                col_n = '0;
                                cur_n = line_start;
                            end
                            CODE_LF: do_nl = 1'b1;
                            CODE_BS: begin
                                if (col != '0) begin
                                    state_n = WRITE;
                                    col_n   = col - 1'b1;
                                    cur_n   = cursor_addr - 1'b1;
                                    we_n    = 1'b1;
                                    addr_n  = cursor_addr - 1'b1;
                                    wdata_n = SPACE;
                                    wrap_n  = 1'b0;
                                end
                            end
`ifdef CONSOLE_TAB_EN
                            CW'(9): begin
                                if (tab_next >= (CBW+1)'(COLS)) begin
                                    do_nl = 1'b1;
                                end else begin
                                    col_n = tab_next[CBW-1:0];
                                    cur_n = line_start + AW'(tab_next);
                                end
                            end
`endif
                            default: ;
                        endcase
                    end
                end
            end
            WRITE: begin
                wrap_n = 1'b0;
                if (wrap_pend) begin
                    state_n = CLRLINE;
                    we_n    = 1'b1;
                    addr_n  = cursor_addr;
                    wdata_n = SPACE;
                end else begin
                    state_n = IDLE;
                end
            end
            CLRLINE: begin
                if (scr_addr == cursor_addr + COLS_M1) begin
                    state_n = IDLE;
                end else begin
                    we_n   = 1'b1;
                    addr_n = scr_addr + 1'b1;
                end
            end
            CLEAR: begin
                if (scr_addr == SCR_LAST) begin
                    state_n = IDLE;
                    col_n   = '0;
                    row_n   = '0;
                    cur_n   = '0;
                end else begin
                    we_n   = 1'b1;
                    addr_n = scr_addr + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        // Newline from LF or an overflowing TAB; wrapping off the last row clears the new row.
        if (do_nl) begin
            col_n = '0;
            row_n = nl_row;
            cur_n = nl_cur;
            if (row_wrap) begin
                state_n = CLRLINE;
                we_n    = 1'b1;
                addr_n  = nl_cur;
                wdata_n = SPACE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            col         <= '0;
            row         <= '0;
            cursor_addr <= '0;
            scr_we      <= 1'b0;
            scr_addr    <= '0;
            scr_wdata   <= '0;
            char_ready  <= 1'b1;
            busy        <= 1'b0;
            wrap_pend   <= 1'b0;
        end else begin
            state       <= state_n;
            col         <= col_n;
            row         <= row_n;
            cursor_addr <= cur_n;
            scr_we      <= we_n;
            scr_addr    <= addr_n;
            scr_wdata   <= wdata_n;
            char_ready  <= (state_n == IDLE);
            busy        <= (state_n != IDLE);
            wrap_pend   <= wrap_n;
        end
    end
endmodule
